uart_rom_loader: RTL and testbench

//  Serial boot loader: the source end of the dn_addr/dn_data/dn_wr/dn_index ROM-upload bus that the SoC's

---
 rtl/uart_rom_loader.sv | 199 +++++++++++++++++++
 tb/tb_uart_rom_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: 8N1 UART receiver feeding a framed ROM-upload parser that drives the dn_* download bus
module uart_rom_loader #(
  parameter int CLKS_PER_BIT = 217,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_CLKS = 2000000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [7:0]        dn_index,
  output logic              dn_download,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {S_IDLE, S_IDX, S_LENH, S_LENL, S_DATA, S_CSUM} st_t;

  logic s1_q, s2_q, prev_q;
  rx_t rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;
  st_t st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d, idx_q, idx_d, sum_q, sum_d;
  logic [15:0] rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic wr_q, wr_d, dl_q, dl_d, done_q, done_d, err_q, err_d;

  // Synchroniser (idle-high preset) plus one extra stage for falling-edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= uart_rx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Receiver: start-bit midpoint recheck, then one sample per bit period, LSB first
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (prev_q && !s2_q) rx_st_d = R_START;
      end
      R_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = 3'd0;
        rx_st_d = s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {s2_q, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rx_st_d = R_STOP;
      end
      R_STOP: if (cnt_q == FULL) begin
        rx_st_d    = R_IDLE;
        rx_valid_d = s2_q;
        rx_ferr_d  = !s2_q;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rx_st_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      sh_q       <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Frame parser: abort on framing error or inter-byte timeout, otherwise advance per received byte
  always_comb begin
    st_d   = st_q;
    addr_d = wr_q ? addr_q + 1'b1 : addr_q;
    data_d = data_q;
    idx_d  = idx_q;
    wr_d   = 1'b0;
    dl_d   = dl_q;
    done_d = 1'b0;
    err_d  = err_q;
    rem_d  = rem_q;
    sum_d  = sum_q;
    tmo_d  = (st_q == S_IDLE || rx_valid_q) ? '0 : tmo_q + 1'b1;
    if (st_q != S_IDLE && (rx_ferr_q || tmo_q == TMAX)) begin
      err_d = 1'b1;
      dl_d  = 1'b0;
      st_d  = S_IDLE;
    end else if (rx_valid_q) begin
      case (st_q)
        S_IDLE: if (sh_q == 8'hA5) begin
          dl_d   = 1'b1;
          err_d  = 1'b0;
          addr_d = '0;
          sum_d  = 8'd0;
          st_d   = S_IDX;
        end
        S_IDX: begin
          idx_d = sh_q;
          st_d  = S_LENH;
        end
        S_LENH: begin
          rem_d[15:8] = sh_q;
          st_d        = S_LENL;
        end
        S_LENL: begin
          rem_d = {rem_q[15:8], sh_q};
          st_d  = ({rem_q[15:8], sh_q} == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: begin
          data_d = sh_q;
          wr_d   = 1'b1;
          sum_d  = sum_q + sh_q;
          rem_d  = rem_q - 1'b1;
          if (rem_q == 16'd1) st_d = S_CSUM;
        end
        S_CSUM: begin
          done_d = (sh_q == sum_q);
          err_d  = (sh_q != sum_q);
          dl_d   = 1'b0;
          st_d   = S_IDLE;
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  // Parser state and download bus registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= S_IDLE;
      addr_q <= '0;
      data_q <= 8'd0;
      idx_q  <= 8'd0;
      wr_q   <= 1'b0;
      dl_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rem_q  <= 16'd0;
      sum_q  <= 8'd0;
      tmo_q  <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      data_q <= data_d;
      idx_q  <= idx_d;
      wr_q   <= wr_d;
      dl_q   <= dl_d;
      done_q <= done_d;
      err_q  <= err_d;
      rem_q  <= rem_d;
      sum_q  <= sum_d;
      tmo_q  <= tmo_d;
    end
  end

  assign dn_addr     = addr_q;
  assign dn_data     = data_q;
  assign dn_wr       = wr_q;
  assign dn_index    = idx_q;
  assign dn_download = dl_q;
  assign cpu_reset   = dl_q;
  assign load_done   = done_q;
  assign load_err    = err_q;
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: drives UART frames into two loaders (wide and 2-bit address) and checks them against a frame-level model
module tb_uart_rom_loader;
  logic clk = 1'b0, reset_n = 1'b0, uart_rx = 1'b1;
  logic [13:0] a_addr;
  logic [1:0]  b_addr;
  logic [7:0]  a_data, b_data, a_idx, b_idx;
  logic a_wr, b_wr, a_dl, b_dl, a_cr, b_cr, a_done, b_done, a_err, b_err;

  int n_chk = 0, n_fail = 0;
  int done_a = 0, done_b = 0, wrs_a = 0, last_a_addr = 0, last_b_addr = 0;
  logic [7:0] last_a_data = 8'd0;

  typedef struct {int addr; logic [7:0] data; logic [7:0] idx;} wr_t;
  wr_t qa[$], qb[$], ea, eb;
  logic [7:0] dq[$];

  uart_rom_loader #(.CLKS_PER_BIT(8), .ADDR_W(14), .TIMEOUT_CLKS(400)) dut_a (
    .clk_sys(clk), .reset_n(reset_n), .uart_rx(uart_rx), .dn_addr(a_addr), .dn_data(a_data),
    .dn_wr(a_wr), .dn_index(a_idx), .dn_download(a_dl), .cpu_reset(a_cr), .load_done(a_done), .load_err(a_err));

  uart_rom_loader #(.CLKS_PER_BIT(8), .ADDR_W(2), .TIMEOUT_CLKS(400)) dut_b (
    .clk_sys(clk), .reset_n(reset_n), .uart_rx(uart_rx), .dn_addr(b_addr), .dn_data(b_data),
    .dn_wr(b_wr), .dn_index(b_idx), .dn_download(b_dl), .cpu_reset(b_cr), .load_done(b_done), .load_err(b_err));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(8);
    end
    uart_rx = stop;
    tick(8);
    uart_rx = 1'b1;
    tick(16);
  endtask

  task automatic push_wr(input int i, input logic [7:0] d, input logic [7:0] idx);
    qa.push_back('{i % 16384, d, idx});
    qb.push_back('{i % 4, d, idx});
  endtask

  task automatic run_frame(input logic [7:0] idx, input logic [7:0] cs);
    int s = 0, wa = wrs_a, da = done_a, db = done_b;
    logic ok;
    foreach (dq[i]) begin
      push_wr(i, dq[i], idx);
      s += dq[i];
    end
    ok = ((s % 256) == cs);
    send_byte(8'hA5);
    chk("frame_dl_a", a_dl, 1);
    chk("frame_cpu_reset_b", b_cr, 1);
    send_byte(idx);
    send_byte(8'(dq.size() >> 8));
    send_byte(8'(dq.size() & 255));
    foreach (dq[i]) send_byte(dq[i]);
    send_byte(cs);
    tick(20);
    chk("done_a", done_a - da, ok);
    chk("done_b", done_b - db, ok);
    chk("err_a", a_err, !ok);
    chk("err_b", b_err, !ok);
    chk("end_dl_a", a_dl, 0);
    chk("end_cpu_reset_b", b_cr, 0);
    chk("wr_count_a", wrs_a - wa, dq.size());
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
  endtask

  // Per-cycle comparison of the download bus against the expected write queues
  always @(negedge clk) begin
    if (reset_n) begin
      chk("a_cpu_reset_eq", a_cr, a_dl);
      chk("b_cpu_reset_eq", b_cr, b_dl);
      if (a_wr) begin
        wrs_a++;
        last_a_addr = a_addr;
        last_a_data = a_data;
        chk("a_wr_in_download", a_dl, 1);
        chk("a_wr_expected", qa.size() > 0, 1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          chk("a_wr_addr", a_addr, ea.addr);
          chk("a_wr_data", a_data, ea.data);
          chk("a_wr_index", a_idx, ea.idx);
        end
      end
      if (b_wr) begin
        last_b_addr = b_addr;
        chk("b_wr_expected", qb.size() > 0, 1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          chk("b_wr_addr", b_addr, eb.addr);
          chk("b_wr_data", b_data, eb.data);
          chk("b_wr_index", b_idx, eb.idx);
        end
      end
      if (a_done) done_a++;
      if (b_done) done_b++;
    end
  end

  initial begin
    tick(5);
    chk("reset_a", {a_addr, a_data, a_wr, a_idx, a_dl, a_cr, a_done, a_err}, 0);
    chk("reset_b", {b_addr, b_data, b_wr, b_idx, b_dl, b_cr, b_done, b_err}, 0);
    reset_n = 1'b1;
    tick(5);

    dq = '{8'h11, 8'h22, 8'h33};
    run_frame(8'h00, 8'h66);
    chk("t1_last_addr", last_a_addr, 2);
    chk("t1_last_data", last_a_data, 8'h33);

    dq = '{8'hAA, 8'hBB};
    run_frame(8'h01, 8'h00);
    chk("t2_index", a_idx, 8'h01);

    send_byte(8'h5A);
    send_byte(8'hFF);
    tick(10);
    chk("t3_stray_err_kept", a_err, 1);
    chk("t3_stray_dl", a_dl, 0);
    dq = '{};
    run_frame(8'h00, 8'h00);

    dq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame(8'h00, 8'h0F);
    chk("t4_wrap_b", last_b_addr, 0);
    chk("t4_nowrap_a", last_a_addr, 4);

    push_wr(0, 8'h11, 8'h00);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    tick(20);
    chk("t5_err_a", a_err, 1);
    chk("t5_err_b", b_err, 1);
    chk("t5_dl_a", a_dl, 0);
    chk("t5_pending_a", qa.size(), 0);
    dq = '{8'h11, 8'h22, 8'h33};
    run_frame(8'h00, 8'h66);

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(340);
    chk("t6_before_timeout_err", a_err, 0);
    chk("t6_before_timeout_dl", a_dl, 1);
    for (int i = 0; i < 100 && !a_err; i++) tick(1);
    chk("t6_timeout_err_a", a_err, 1);
    chk("t6_timeout_dl_a", a_dl, 0);
    chk("t6_timeout_err_b", b_err, 1);

    push_wr(0, 8'h11, 8'h00);
    push_wr(1, 8'h22, 8'h00);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t6b_mid_dl", a_dl, 1);
    uart_rx = 1'b0;
    tick(20);
    #2 reset_n = 1'b0;
    #1;
    chk("t6b_async_reset_a", {a_addr, a_data, a_wr, a_idx, a_dl, a_cr, a_done, a_err}, 0);
    chk("t6b_async_reset_b", {b_addr, b_data, b_wr, b_idx, b_dl, b_cr, b_done, b_err}, 0);
    uart_rx = 1'b1;
    tick(30);
    reset_n = 1'b1;
    tick(5);
    chk("t6b_pending_a", qa.size(), 0);
    chk("t6b_pending_b", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
